// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit: RV32 funct3 size codes,
// FSM state encoding and the funct3 -> transfer byte count mapping.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    // Size is carried in func3[1:0]; the unsigned bit does not change width.
    function automatic logic [2:0] byte_count(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend
// Combinational load-result formatter: takes the little-endian byte buffer
// and the RV32 funct3 size code and returns the sign- or zero-extended word.
// Reusable by the writeback mux.
// Ports:
//   func3  in  3   load size/sign code
//   data   in  32  assembled bytes, byte 0 in [7:0]
//   result out 32  extended load value
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (func3)
            F3_B:    result = {{24{data[7]}}, data[7:0]};
            F3_H:    result = {{16{data[15]}}, data[15:0]};
            F3_BU:   result = {24'h000000, data[7:0]};
            F3_HU:   result = {16'h0000, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of a byte-wide single-port data memory. Accepts one
// load/store request, moves 1/2/4 bytes little-endian (one per cycle),
// extends load data and returns a single-cycle response.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned H/HU/W
// accesses with resp_err instead of performing them byte by byte.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_func3          store flag, RV32 size code
//   req_addr, req_wdata        lowest byte address, store data
//   resp_valid/rdata/err       one-cycle completion pulse and result
//   mem_re, mem_we             memory strobes (one byte per cycle)
//   mem_addr, mem_wdata        memory byte address and write byte
//   mem_rdata                  combinational read byte
//
// state | meaning
// IDLE  | ready for a request
// XFER  | one byte moved per cycle, idx 0..N-1
// RESP  | resp_valid pulse, then back to IDLE
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [31:0] rbuf_nxt;
    logic [31:0] ext_data;
    logic        req_legal;

    always_comb begin
        req_legal = 1'b1;
        case (req_func3)
            3'b011, 3'b110, 3'b111: req_legal = 1'b0;
            F3_BU, F3_HU:           if (req_we) req_legal = 1'b0;
            default:                ;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((req_func3[1:0] == 2'b01) && req_addr[0])
            req_legal = 1'b0;
        if ((req_func3 == F3_W) && (req_addr[1:0] != 2'b00))
            req_legal = 1'b0;
`endif
    end

    // Buffer including the byte arriving this cycle, so the final byte is
    // already part of the extended result registered on the last XFER edge.
    always_comb begin
        rbuf_nxt = rbuf_q;
        case (idx_q)
            2'd0: rbuf_nxt[7:0]   = mem_rdata;
            2'd1: rbuf_nxt[15:8]  = mem_rdata;
            2'd2: rbuf_nxt[23:16] = mem_rdata;
            2'd3: rbuf_nxt[31:24] = mem_rdata;
            default: ;
        endcase
    end

    load_extend u_load_extend (
        .func3  (f3_q),
        .data   (rbuf_nxt),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        f3_q      <= req_func3;
                        idx_q     <= '0;
                        last_q    <= 2'(byte_count(req_func3) - 3'd1);
                        rbuf_q    <= '0;
                        // Byte 0 goes out now; the rest shift down one per cycle.
                        wdata_q   <= {8'h00, req_wdata[31:8]};
                        if (req_legal) begin
                            state     <= XFER;
                            mem_addr  <= req_addr;
                            mem_re    <= ~req_we;
                            mem_we    <= req_we;
                            mem_wdata <= req_wdata[7:0];
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                XFER: begin
                    if (!we_q)
                        rbuf_q <= rbuf_nxt;
                    if (idx_q == last_q) begin
                        state      <= RESP;
                        mem_re     <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? 32'h0 : ext_data;
                    end else begin
                        idx_q     <= idx_q + 2'd1;
                        mem_addr  <= mem_addr + ADDR_ONE;
                        mem_wdata <= wdata_q[7:0];
                        wdata_q   <= {8'h00, wdata_q[31:8]};
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int both_cnt = 0;

    logic [7:0] mem [0:255];
    logic [7:0] wlog_addr [$];
    logic [7:0] wlog_data [$];
    int         wlog_cyc  [$];
    logic [7:0] rlog_addr [$];

    load_store_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
            wlog_cyc.push_back(cyc_cnt);
        end
        if (mem_re) rlog_addr.push_back(mem_addr);
        if (mem_re && mem_we) both_cnt++;
    end

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
        rlog_addr.delete();
    endtask

    // Waits for IDLE, performs one handshake and returns the response cycle
    // (1 = cycle after the handshake; 20 means no response seen).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wdata, output int rcyc,
                         output logic [31:0] rd, output logic err, output int hs_cyc);
        @(negedge clk);
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        hs_cyc = cyc_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rcyc = 1;
        while (!resp_valid && rcyc < 20) begin
            @(posedge clk);
            #1 rcyc++;
        end
        rd = resp_rdata;
        err = resp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_re, mem_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, resp_err, mem_re, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data got addr %h wdata %h rdata %h want 0", mem_addr, mem_wdata, resp_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        int rc, hs; logic [31:0] rd; logic er;
        logic [7:0] exp_b [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        clear_logs();
        issue(1'b1, W, 8'h10, 32'hA1B2C3D4, rc, rd, er, hs);
        checks++;
        if (rc !== 5 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_w_resp got cyc %0d rdata %h err %b want 5 0 0", rc, rd, er);
        end
        checks++;
        if (wlog_addr.size() != 4 || rlog_addr.size() != 0) begin
            errors++;
            $display("FAIL store_w_count got writes %0d reads %0d want 4 0", wlog_addr.size(), rlog_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog_addr[i] !== 8'h10 + 8'(i) || wlog_data[i] !== exp_b[i] || wlog_cyc[i] - hs != i + 1) begin
                    errors++;
                    $display("FAIL store_w_byte%0d got addr %h data %h cyc %0d want %h %h %0d",
                             i, wlog_addr[i], wlog_data[i], wlog_cyc[i] - hs, 8'h10 + 8'(i), exp_b[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s  [7];
        logic [7:0]  adrs [7];
        logic [31:0] exps [7];
        int          cycs [7];
        int rc, hs; logic [31:0] rd; logic er;
        f3s  = '{B, BU, H, HU, W, B, BU};
        adrs = '{8'h13, 8'h13, 8'h10, 8'h10, 8'h10, 8'h10, 8'h11};
        exps = '{32'hFFFFFFA1, 32'h000000A1, 32'hFFFFC3D4, 32'h0000C3D4,
                 32'hA1B2C3D4, 32'hFFFFFFD4, 32'h000000C3};
        cycs = '{2, 2, 3, 3, 5, 2, 2};
        mem[8'h30] = 8'h7F; mem[8'h31] = 8'h12;
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'hFFFFFFFF, rc, rd, er, hs);
            checks++;
            if (rd !== exps[i] || er !== 1'b0 || rc !== cycs[i]) begin
                errors++;
                $display("FAIL load_%0d got rdata %h err %b cyc %0d want %h 0 %0d",
                         i, rd, er, rc, exps[i], cycs[i]);
            end
        end
        issue(1'b0, H, 8'h30, 32'h0, rc, rd, er, hs);
        checks++;
        if (rd !== 32'h0000127F) begin
            errors++;
            $display("FAIL load_h_pos got %h want 0000127F", rd);
        end
    endtask

    task automatic test_wrap();
        int rc, hs; logic [31:0] rd; logic er;
        mem[8'hFF] = 8'h80; mem[8'h00] = 8'h7F;
        clear_logs();
        issue(1'b0, H, 8'hFF, 32'h0, rc, rd, er, hs);
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (er !== 1'b1 || rc !== 1 || rd !== 32'h0 || rlog_addr.size() != 0) begin
            errors++;
            $display("FAIL wrap_trap got err %b cyc %0d rdata %h reads %0d want 1 1 0 0",
                     er, rc, rd, rlog_addr.size());
        end
`else
        checks++;
        if (er !== 1'b0 || rc !== 3 || rd !== 32'h00007F80) begin
            errors++;
            $display("FAIL wrap_h got err %b cyc %0d rdata %h want 0 3 00007F80", er, rc, rd);
        end
        checks++;
        if (rlog_addr.size() != 2) begin
            errors++;
            $display("FAIL wrap_reads got %0d reads want 2", rlog_addr.size());
        end else if (rlog_addr[0] !== 8'hFF || rlog_addr[1] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_reads got %h %h want FF 00", rlog_addr[0], rlog_addr[1]);
        end
`endif
    endtask

    task automatic test_illegal();
        int rc, hs; logic [31:0] rd; logic er;
        clear_logs();
        issue(1'b1, 3'b100, 8'h40, 32'hDEADBEEF, rc, rd, er, hs);
        checks++;
        if (er !== 1'b1 || rc !== 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL illegal_store_bu got err %b cyc %0d rdata %h want 1 1 0", er, rc, rd);
        end
        issue(1'b0, 3'b011, 8'h40, 32'h0, rc, rd, er, hs);
        checks++;
        if (er !== 1'b1 || rc !== 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL illegal_f3_011 got err %b cyc %0d rdata %h want 1 1 0", er, rc, rd);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wlog_addr.size() != 0 || rlog_addr.size() != 0) begin
            errors++;
            $display("FAIL illegal_no_access got writes %0d reads %0d want 0 0",
                     wlog_addr.size(), rlog_addr.size());
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        for (int i = 0; i < 4; i++) mem[8'h20 + 8'(i)] = 8'h55;
        @(negedge clk);
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        req_we = 1'b1; req_func3 = W; req_addr = 8'h20; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        if (resp_valid) seen++;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got ready %b we %b want 1 0", req_ready, mem_we);
        end
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_resp got %0d resp pulses want 0", seen);
        end
        checks++;
        if (mem[8'h20] !== 8'h44 || mem[8'h21] !== 8'h33 || mem[8'h22] !== 8'h55 || mem[8'h23] !== 8'h55) begin
            errors++;
            $display("FAIL abort_mem got %h %h %h %h want 44 33 55 55",
                     mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
        end
    endtask

    task automatic test_back_to_back();
        int hs = 0, rsp = 0, ov = 0;
        @(negedge clk);
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        req_we = 1'b0; req_func3 = BU; req_addr = 8'h13;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (req_valid && req_ready) hs++;
            if (resp_valid) rsp++;
            if (req_ready && (mem_re || mem_we || resp_valid)) ov++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (hs != 3 || rsp != 3) begin
            errors++;
            $display("FAIL b2b_rate got handshakes %0d resps %0d want 3 3", hs, rsp);
        end
        checks++;
        if (ov != 0) begin
            errors++;
            $display("FAIL b2b_overlap got %0d cycles with ready during busy want 0", ov);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_store_word();
        test_load_extend();
        test_wrap();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL strobe_exclusive got %0d cycles with re and we want 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request from the execute stage and drives a byte-wide, single-port data memory.
- Sequences 1, 2 or 4 byte transactions per RV32 funct3 size, little-endian.
- For loads, assembles the bytes and applies sign or zero extension, then returns one response pulse.
- Sits between the ALU address output and the data memory; the memory reads combinationally and writes on the clock edge.

Parameters:
- ADDR_W, 8: byte-address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address of the lowest byte
- req_wdata  in  32  store data; bytes taken LSB first
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; illegal request
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe, one byte per cycle
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  combinational read byte for the current mem_addr

Behaviour:
- Reset (rst_n low at a clk edge) forces the following, all taking effect on that edge:
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, mem_re, mem_we = 0.
  - mem_addr, mem_wdata, resp_rdata = 0.
  - internal buffers are cleared.
- Reset during XFER aborts the access. Bytes already written stay in memory; no response is issued.
- FSM:
  - IDLE: req_ready = 1. A handshake (req_valid && req_ready) latches we, func3, addr, wdata and sets the byte count N = 1/2/4 from func3[1:0]. Byte index idx = 0.
    - Legal request: go to XFER.
    - Illegal request: go to RESP with err = 1.
  - XFER: mem_addr = base + idx (wraps at 2^ADDR_W). mem_re = ~we; mem_we = we; mem_wdata = wdata[8*idx+7 : 8*idx].
    - Loads capture mem_rdata into buffer byte idx at the clock edge.
    - idx increments each cycle; after idx = N-1, go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then go to IDLE. The state also drives resp_rdata and resp_err.
- Illegal requests:
  - func3 = 011, 110 or 111.
  - A store with func3 = 100 or 101.
  - Any illegal request makes no memory access.
- Load extension:
  - B: sign from bit 7. H: sign from bit 15. W: no extension.
  - BU and HU: zero-extend.
- Latency: handshake in cycle 0; memory strobes in cycles 1..N; resp_valid in cycle N+1. Error requests respond in cycle 1.
- No back-to-back acceptance. req_ready is low from the cycle after the handshake until the cycle after resp_valid.
- mem_re and mem_we are never both high. Both are low outside XFER.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined: an H/HU request with addr[0] != 0, or a W request with addr[1:0] != 0, is illegal. It gets resp_err = 1, makes no memory access, and responds in cycle 1.
- When undefined: misaligned accesses are performed byte by byte, exactly like aligned ones, including address wrap-around.

Decomposition:
- Shared package holds:
  - func3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, XFER, RESP.
  - A function mapping func3 to byte count.
- One natural sub-module, load_extend: combinational buffer + func3 -> 32-bit extended result. It is reusable by the writeback mux.

Test Plan:
- Store W, addr 0x10, wdata 0xA1B2C3D4 -> mem_we on cycles 1-4 at 0x10..0x13 with bytes D4, C3, B2, A1; resp_valid in cycle 5, resp_rdata 0, err 0.
- Load B, addr 0x13 (holding 0xA1) -> resp_rdata 0xFFFFFFA1. Load BU on the same address -> 0x000000A1.
- Load H, addr 0xFF (ADDR_W 8; mem[0xFF] = 0x80, mem[0x00] = 0x7F) -> reads 0xFF then 0x00; resp_rdata 0x00007F80. With MISALIGN_TRAP_EN: err = 1, no mem_re.
- Store with func3 100 and a load with func3 011 -> both respond in cycle 1 with err = 1; no mem_we or mem_re ever asserted.
- rst_n low in XFER cycle 2 of a W store at 0x20 -> only 0x20 and 0x21 written; no resp_valid; req_ready = 1 one cycle after reset is released.
- req_valid held high continuously -> requests accepted only in IDLE. A 1-byte request cycles IDLE -> XFER -> RESP (3 cycles), and req_ready never overlaps XFER or RESP.
